// File: rtl/ninjakun_inpcond_if.sv
// Input-conditioner bus: raw arcade controls in, negative-logic control bytes out.
// master drives JOY1/JOY2/START1/START2/COIN1/COIN2/SERVICE/VBLK and reads CTR1o..CTR3o;
// slave (the conditioner) does the reverse.
interface ninjakun_inpcond_if;
    logic [5:0] JOY1;
    logic [5:0] JOY2;
    logic       START1;
    logic       START2;
    logic       COIN1;
    logic       COIN2;
    logic       SERVICE;
    logic       VBLK;
    logic [7:0] CTR1o;
    logic [7:0] CTR2o;
    logic [7:0] CTR3o;

    modport master (
        output JOY1, JOY2, START1, START2,
        output COIN1, COIN2, SERVICE, VBLK,
        input  CTR1o, CTR2o, CTR3o
    );

    modport slave (
        input  JOY1, JOY2, START1, START2,
        input  COIN1, COIN2, SERVICE, VBLK,
        output CTR1o, CTR2o, CTR3o
    );
endinterface

// File: rtl/ninjakun_inpcond.sv
// Ninjakun input conditioner: synchronizes and debounces the player controls,
// shapes each coin press into a frame-timed pulse, and packs the negative-logic
// control bytes.
// Ports: INPCL clock, RESET async active-high, bus (slave modport) carrying
//   JOY1/JOY2 {B2,B1,Down,Up,Left,Right}, START1/2, COIN1/2, SERVICE, VBLK in
//   and CTR1o = ~{START1,COIN1P,J1}, CTR2o = ~{START2,COIN2P,J2},
//   CTR3o = {7'h7F,~SERVICE} out.
// Parameters: DEB_DIV (cycles per debounce tick), COIN_FRAMES (pulse/gap frames).
// Option: define NINJAKUN_INPCOND_SOCD_EN to cancel opposing joystick directions.
module ninjakun_inpcond #(
    parameter int DEB_DIV     = 1024,
    parameter int COIN_FRAMES = 3
) (
    input logic               INPCL,
    input logic               RESET,
    ninjakun_inpcond_if.slave bus
);

    localparam int          NB       = 17;
    localparam logic [3:0]  CF       = 4'(COIN_FRAMES);
    localparam logic [15:0] DIV_LAST = 16'(DEB_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_st_e;

    // Bit map: [5:0] JOY1, [11:6] JOY2, 12 START1, 13 START2,
    // 14 COIN1, 15 COIN2, 16 SERVICE.
    logic [NB-1:0] raw;
    assign raw = {bus.SERVICE, bus.COIN2, bus.COIN1,
                  bus.START2, bus.START1, bus.JOY2, bus.JOY1};

    logic [NB-1:0] sync1_q, sync2_q;
    logic [NB-1:0] hist1_q, hist2_q;
    logic [NB-1:0] deb_q, deb_d;
    logic          vblk1_q, vblk2_q, vblk3_q;
    logic [15:0]   pre_q, pre_d;
    logic [1:0]    coin_prev_q;
    logic          tick;
    logic          frame;
    logic [1:0]    rise;
    logic [1:0]    coinp;

    assign tick  = (pre_q == DIV_LAST);
    assign pre_d = tick ? 16'd0 : pre_q + 16'd1;
    assign frame = vblk2_q & ~vblk3_q;
    assign rise  = deb_q[15:14] & ~coin_prev_q;

    // A bit only moves when this tick's sample and the two before it agree.
    always_comb begin
        logic [NB-1:0] agree;
        agree = ~(sync2_q ^ hist1_q) & ~(sync2_q ^ hist2_q);
        deb_d = deb_q;
        if (tick) begin
            deb_d = (agree & sync2_q) | (~agree & deb_q);
        end
    end

    always_ff @(posedge INPCL or posedge RESET) begin
        if (RESET) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            hist1_q     <= '0;
            hist2_q     <= '0;
            deb_q       <= '0;
            vblk1_q     <= 1'b0;
            vblk2_q     <= 1'b0;
            vblk3_q     <= 1'b0;
            pre_q       <= '0;
            coin_prev_q <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            vblk1_q     <= bus.VBLK;
            vblk2_q     <= vblk1_q;
            vblk3_q     <= vblk2_q;
            pre_q       <= pre_d;
            deb_q       <= deb_d;
            coin_prev_q <= deb_q[15:14];
            if (tick) begin
                hist1_q <= sync2_q;
                hist2_q <= hist1_q;
            end
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_coin
        coin_st_e   st_q, st_d;
        logic [3:0] cnt_q, cnt_d;
        logic       pend_q, pend_d;

        always_ff @(posedge INPCL or posedge RESET) begin
            if (RESET) begin
                st_q   <= IDLE;
                cnt_q  <= '0;
                pend_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                pend_q <= pend_d;
            end
        end

        // In IDLE a press wins over a coincident frame: the pulse starts
        // with a full count. A press arriving with the last gap frame is
        // taken as the pending press.
        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            pend_d = pend_q;
            unique case (st_q)
                IDLE: begin
                    if (rise[c]) begin
                        st_d  = PULSE;
                        cnt_d = CF;
                    end
                end
                PULSE: begin
                    if (rise[c]) pend_d = 1'b1;
                    if (frame) begin
                        if (cnt_q == 4'd1) begin
                            st_d  = GAP;
                            cnt_d = CF;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (rise[c]) pend_d = 1'b1;
                    if (frame) begin
                        if (cnt_q == 4'd1) begin
                            if (pend_d) begin
                                st_d   = PULSE;
                                cnt_d  = CF;
                                pend_d = 1'b0;
                            end else begin
                                st_d  = IDLE;
                                cnt_d = 4'd0;
                            end
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    st_d   = IDLE;
                    cnt_d  = 4'd0;
                    pend_d = 1'b0;
                end
            endcase
        end

        assign coinp[c] = (st_q == PULSE);
    end

    logic [5:0] j1, j2;

`ifdef NINJAKUN_INPCOND_SOCD_EN
    function automatic logic [5:0] socd(input logic [5:0] j);
        logic [5:0] r;
        r = j;
        if (j[0] & j[1]) r[1:0] = 2'b00;
        if (j[2] & j[3]) r[3:2] = 2'b00;
        return r;
    endfunction

    assign j1 = socd(deb_q[5:0]);
    assign j2 = socd(deb_q[11:6]);
`else
    assign j1 = deb_q[5:0];
    assign j2 = deb_q[11:6];
`endif

    assign bus.CTR1o = ~{deb_q[12], coinp[0], j1};
    assign bus.CTR2o = ~{deb_q[13], coinp[1], j2};
    assign bus.CTR3o = {7'h7F, ~deb_q[16]};

endmodule

// File: tb/tb_ninjakun_inpcond.sv
// Self-checking bench for ninjakun_inpcond: directed scenarios plus random
// traffic compared against a behavioural model of debounce and coin timing.
module tb_ninjakun_inpcond;

    localparam int DEB_DIV     = 4;
    localparam int COIN_FRAMES = 3;

    logic clk;
    logic rst;

    ninjakun_inpcond_if bus ();

    ninjakun_inpcond #(
        .DEB_DIV    (DEB_DIV),
        .COIN_FRAMES(COIN_FRAMES)
    ) dut (
        .INPCL(clk),
        .RESET(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Model state: debounced values, tick sample history, coin timing.
    logic [16:0] m_deb;
    logic [16:0] samp[$];
    bit          m_vprev;
    int          pl[2];
    int          gl[2];
    bit          pend[2];
    bit          rise[2];

    function automatic logic [5:0] m_socd(input logic [5:0] j);
        logic [5:0] r;
        r = j;
`ifdef NINJAKUN_INPCOND_SOCD_EN
        if (j[0] && j[1]) begin r[0] = 1'b0; r[1] = 1'b0; end
        if (j[2] && j[3]) begin r[2] = 1'b0; r[3] = 1'b0; end
`endif
        return r;
    endfunction

    function automatic logic [23:0] m_out();
        logic [7:0] a, b, c;
        a = ~{m_deb[12], 1'(pl[0] > 0), m_socd(m_deb[5:0])};
        b = ~{m_deb[13], 1'(pl[1] > 0), m_socd(m_deb[11:6])};
        c = {7'h7F, ~m_deb[16]};
        return {a, b, c};
    endfunction

    task automatic m_reset();
        m_deb   = '0;
        samp    = {17'h0, 17'h0};
        m_vprev = 1'b0;
        for (int c = 0; c < 2; c++) begin
            pl[c] = 0; gl[c] = 0; pend[c] = 0; rise[c] = 0;
        end
    endtask

    task automatic m_tick(input logic [16:0] s);
        logic [16:0] old;
        old = m_deb;
        samp.push_back(s);
        while (samp.size() > 3) void'(samp.pop_front());
        for (int b = 0; b < 17; b++) begin
            if (samp[0][b] == samp[1][b] && samp[1][b] == samp[2][b])
                m_deb[b] = samp[2][b];
        end
        rise[0] = m_deb[14] && !old[14];
        rise[1] = m_deb[15] && !old[15];
    endtask

    task automatic m_edge(input int c);
        if (pl[c] == 0 && gl[c] == 0) pl[c] = COIN_FRAMES;
        else pend[c] = 1'b1;
    endtask

    task automatic m_frame(input int c);
        if (pl[c] > 0) begin
            pl[c]--;
            if (pl[c] == 0) gl[c] = COIN_FRAMES;
        end else if (gl[c] > 0) begin
            gl[c]--;
            if (gl[c] == 0 && pend[c]) begin
                pend[c] = 1'b0;
                pl[c]   = COIN_FRAMES;
            end
        end
    endtask

    task automatic drive(input logic [16:0] r, input bit vb);
        bus.JOY1    = r[5:0];
        bus.JOY2    = r[11:6];
        bus.START1  = r[12];
        bus.START2  = r[13];
        bus.COIN1   = r[14];
        bus.COIN2   = r[15];
        bus.SERVICE = r[16];
        bus.VBLK    = vb;
    endtask

    // One debounce period, entered at the negedge after a tick edge.
    // A coin press found at the previous tick acts early in the period,
    // a VBLK rise driven now acts later in the same period.
    task automatic period(input logic [16:0] r, input bit vb);
        logic [23:0] got, exp;
        drive(r, vb);
        for (int c = 0; c < 2; c++) begin
            if (rise[c]) m_edge(c);
            rise[c] = 1'b0;
        end
        if (vb && !m_vprev) begin
            m_frame(0);
            m_frame(1);
        end
        m_vprev = vb;
        exp = m_out();
        repeat (DEB_DIV - 1) @(posedge clk);
        #1;
        got = {bus.CTR1o, bus.CTR2o, bus.CTR3o};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL pre_tick t=%0t: got %h expected %h", $time, got, exp);
        end
        @(posedge clk);
        m_tick(r);
        exp = m_out();
        #1;
        got = {bus.CTR1o, bus.CTR2o, bus.CTR3o};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL post_tick t=%0t: got %h expected %h", $time, got, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(17'($urandom), 1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.CTR1o !== 8'hFF) begin
            failures++;
            $display("FAIL reset_ctr1: got %h expected ff", bus.CTR1o);
        end
        checks++;
        if (bus.CTR2o !== 8'hFF) begin
            failures++;
            $display("FAIL reset_ctr2: got %h expected ff", bus.CTR2o);
        end
        checks++;
        if (bus.CTR3o !== 8'hFF) begin
            failures++;
            $display("FAIL reset_ctr3: got %h expected ff", bus.CTR3o);
        end
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_debounce();
        logic [16:0] j;
        j = 17'h1;
        period(j, 0);
        period(j, 0);
        period('0, 0);
        checks++;
        if (bus.CTR1o[0] !== 1'b1) begin
            failures++;
            $display("FAIL deb_short: got %b expected 1", bus.CTR1o[0]);
        end
        period(j, 0);
        period(j, 0);
        checks++;
        if (bus.CTR1o[0] !== 1'b1) begin
            failures++;
            $display("FAIL deb_two: got %b expected 1", bus.CTR1o[0]);
        end
        period(j, 0);
        checks++;
        if (bus.CTR1o[0] !== 1'b0) begin
            failures++;
            $display("FAIL deb_three: got %b expected 0", bus.CTR1o[0]);
        end
        repeat (3) period('0, 0);
    endtask

    task automatic test_service();
        logic [16:0] s;
        s = 17'h1_0000;
        repeat (4) period(s, 0);
        checks++;
        if (bus.CTR3o !== 8'hFE) begin
            failures++;
            $display("FAIL service_on: got %h expected fe", bus.CTR3o);
        end
        repeat (4) period('0, 0);
        checks++;
        if (bus.CTR3o !== 8'hFF) begin
            failures++;
            $display("FAIL service_off: got %h expected ff", bus.CTR3o);
        end
    endtask

    task automatic test_coin_single();
        logic [16:0] c1;
        int npulse;
        bit prev_act, act;
        c1 = 17'h0_4000;
        npulse = 0;
        prev_act = 1'b0;
        for (int i = 0; i < 28; i++) begin
            period((i < 3) ? c1 : 17'h0, bit'(i % 2));
            act = !bus.CTR1o[6];
            if (act && !prev_act) npulse++;
            prev_act = act;
        end
        checks++;
        if (npulse != 1) begin
            failures++;
            $display("FAIL coin_single_count: got %0d expected 1", npulse);
        end
    endtask

    task automatic test_coin_multi();
        logic [16:0] c1;
        int npulse;
        bit prev_act, act;
        c1 = 17'h0_4000;
        npulse = 0;
        prev_act = 1'b0;
        for (int i = 0; i < 18; i++) begin
            period(((i / 3) % 2 == 0) ? c1 : 17'h0, 1'b0);
            act = !bus.CTR1o[6];
            if (act && !prev_act) npulse++;
            prev_act = act;
        end
        for (int i = 0; i < 40; i++) begin
            period('0, bit'(i % 2));
            act = !bus.CTR1o[6];
            if (act && !prev_act) npulse++;
            prev_act = act;
        end
        checks++;
        if (npulse != 2) begin
            failures++;
            $display("FAIL coin_multi_count: got %0d expected 2", npulse);
        end
    endtask

    task automatic test_socd();
        logic [1:0] want;
`ifdef NINJAKUN_INPCOND_SOCD_EN
        want = 2'b11;
`else
        want = 2'b00;
`endif
        repeat (4) period(17'h0_0003, 0);
        checks++;
        if (bus.CTR1o[1:0] !== want) begin
            failures++;
            $display("FAIL socd_lr: got %b expected %b", bus.CTR1o[1:0], want);
        end
        repeat (4) period(17'h0_0300, 0);
        repeat (4) period(17'h0_0025, 0);
        repeat (3) period('0, 0);
    endtask

    task automatic test_reset_mid_pulse();
        logic [16:0] c2;
        c2 = 17'h0_8000;
        repeat (3) period(c2, 0);
        period('0, 0);
        checks++;
        if (bus.CTR2o !== 8'hBF) begin
            failures++;
            $display("FAIL pulse_before_reset: got %h expected bf", bus.CTR2o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.CTR2o !== 8'hFF) begin
            failures++;
            $display("FAIL async_reset: got %h expected ff", bus.CTR2o);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < 14; i++) period('0, bit'(i % 2));
        checks++;
        if (bus.CTR2o !== 8'hFF) begin
            failures++;
            $display("FAIL no_pulse_after_reset: got %h expected ff", bus.CTR2o);
        end
    endtask

    task automatic test_random();
        logic [16:0] r;
        r = '0;
        for (int i = 0; i < 300; i++) begin
            for (int b = 0; b < 17; b++) begin
                if ($urandom_range(0, 4) == 0) r[b] = ~r[b];
            end
            period(r, bit'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 30; i++) period('0, bit'(i % 2));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive('0, 1'b0);
        m_reset();
        @(negedge clk);
        test_reset();
        test_debounce();
        test_service();
        test_coin_single();
        test_coin_multi();
        test_socd();
        test_reset_mid_pulse();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ninjakun_inpcond.md
NINJAKUN_INPCOND -- requirements
Module: ninjakun_inpcond

Interface
REQ-001 Parameter DEB_DIV, default 1024: INPCL cycles between debounce sample ticks (range 2..65535).
REQ-002 Parameter COIN_FRAMES, default 3: frame count for both the coin pulse width and the coin gap (range 1..15).
REQ-003 INPCL  input  1  system clock; all state is clocked on its rising edge.
REQ-004 RESET  input  1  reset; RESET, asynchronous, active-high.
REQ-005 JOY1, JOY2  input  6 each  raw player controls, active-high, asynchronous; bits {B2,B1,Down,Up,Left,Right} from bit 5 to bit 0.
REQ-006 START1, START2, COIN1, COIN2, SERVICE  input  1 each  raw buttons, active-high, asynchronous.
REQ-007 VBLK  input  1  vertical blank, asynchronous; its rising edge defines one frame.
REQ-008 CTR1o  output  8  negative logic: ~{START1d, COIN1P, J1}.
REQ-009 CTR2o  output  8  negative logic: ~{START2d, COIN2P, J2}.
REQ-010 CTR3o  output  8  {7'h7F, ~SERVICEd}.

Function
REQ-011 Each raw input and VBLK SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 A prescaler SHALL produce a 1-cycle tick every DEB_DIV cycles; the first tick occurs DEB_DIV cycles after reset release.
REQ-013 Each of the 17 synchronized button bits SHALL change its debounced value only when 3 consecutive tick samples agree and differ from the current value; the update takes effect in the tick cycle.
REQ-014 J1/J2 SHALL equal the debounced JOY bits, except when SOCD cleaning is enabled (REQ-023).
REQ-015 A frame event SHALL be the rising edge of synchronized VBLK, detected as a 1-cycle pulse.
REQ-016 Per coin, an FSM SHALL use states IDLE, PULSE, GAP and a 4-bit frame counter.
REQ-017 IDLE->PULSE on the debounced coin 0->1 edge; counter loads COIN_FRAMES; COINxP=1 while in PULSE.
REQ-018 PULSE: counter decrements per frame event; on reaching 0 -> GAP with counter reloaded to COIN_FRAMES.
REQ-019 GAP: COINxP=0; counter decrements per frame event; on reaching 0 -> PULSE if the pending flag is set (flag cleared), else -> IDLE.
REQ-020 A coin 0->1 edge in PULSE or GAP SHALL set a 1-deep pending flag; further edges while the flag is set are dropped.
REQ-021 A coin held high SHALL NOT retrigger; only 0->1 edges count.
REQ-022 A coin edge and a frame event in the same cycle: the edge is handled first (IDLE->PULSE with a full count; the frame event is ignored for that FSM in that cycle).

Reset
REQ-023 (Reserved numbering; see Configuration.)
REQ-024 While RESET=1: CTR1o=CTR2o=CTR3o=8'hFF; synchronizers, debounced values, sample history, prescaler, counters and pending flags all 0; FSMs in IDLE.
REQ-025 Reset asserted mid-PULSE SHALL deassert the coin output immediately (asynchronous); after release, no pulse is generated unless a new 0->1 edge is debounced.

Configuration
REQ-026 Macro NINJAKUN_INPCOND_SOCD_EN defined: per player, debounced Left and Right both 1 -> both output 0; debounced Up and Down both 1 -> both output 0.
REQ-027 Macro NINJAKUN_INPCOND_SOCD_EN undefined: J1/J2 pass the debounced JOY values unmodified.

Verification
REQ-028 DEB_DIV=4; JOY1[0] raised for 2 ticks, then dropped -> CTR1o[0] stays 1; held for 3 ticks -> CTR1o[0]=0 on the 3rd tick cycle.
REQ-029 COIN_FRAMES=3; single COIN1 press -> CTR1o[6]=0 for exactly 3 VBLK edges, then 1 for at least 3 edges, then IDLE.
REQ-030 Three COIN1 edges during PULSE -> exactly 2 pulses total, separated by a 3-frame gap.
REQ-031 RESET pulse during COIN2 PULSE -> CTR2o=8'hFF immediately; after release and with no new edge, CTR2o stays 8'hFF.
REQ-032 JOY1 Left+Right held, macro defined -> CTR1o[1:0]=2'b11; macro undefined -> 2'b00.
REQ-033 SERVICE held -> CTR3o=8'hFE after debounce; released -> 8'hFF.
